adder_pipe: RTL and testbench
=============================

Name: adder_pipe

Overview:
- Parametrised, pipelined successor to the structural ripple-carry adder.
- The carry chain is split into NUM_STAGES equal segments, with one register stage per segment, giving throughput of one operation per cycle.
- Adds subtract mode, signed-overflow flag, transaction tag passthrough and a valid/ready handshake with back-pressure.
- Sits between the operand source and the result consumer in the adder IP; the UVM scoreboard keys on the tag.

Parameters:
- DATA_WIDTH, 32, operand width in bits; must be divisible by NUM_STAGES.
- NUM_STAGES, 4, number of pipeline segments and the latency in cycles; range 1..DATA_WIDTH.
- TAG_WIDTH, 4, width of the opaque tag carried alongside each operation.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept operands this cycle.
- a  input  DATA_WIDTH  operand A.
- b  input  DATA_WIDTH  operand B.
- cin  input  1  carry-in; used in add mode only.
- op_sub  input  1  0 = add, 1 = subtract.
- sat_req  input  1  request signed saturation; only effective with the optional feature.
- in_tag  input  TAG_WIDTH  transaction tag.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts the result.
- sum_ext  output  DATA_WIDTH+1  result; MSB is carry-out.
- overflow  output  1  signed two's-complement overflow of the DATA_WIDTH-bit result.
- out_tag  output  TAG_WIDTH  tag of the presented result.

Behaviour:
- Clock/reset: one clock domain, clk. Reset rst is synchronous and active-high.
- Reset values: all stage valid bits clear; out_valid=0, sum_ext=0, overflow=0, out_tag=0. in_ready=1 in the first cycle after reset deasserts.
- Reset mid-operation: in-flight operations are discarded and produce no output.
- Segmenting: SEG = DATA_WIDTH/NUM_STAGES. A non-integer SEG is an elaboration error ($error).
- Arithmetic:
  - Effective B = op_sub ? ~b : b.
  - Effective carry-in = op_sub ? 1 : cin.
  - Stage k (k = 0..NUM_STAGES-1) adds bits [k*SEG +: SEG] of A and effective B plus the carry registered by stage k-1 (stage 0 uses the effective carry-in).
  - Stage k registers: its partial sum, carry-out, the undone upper operand bits, op_sub/sat_req, tag and valid.
  - Lower result bits already computed are delayed alongside.
- Result:
  - sum_ext[DATA_WIDTH] = final carry-out. In subtract mode, 1 means no borrow.
  - overflow = (A[msb] == effB[msb]) && (sum[msb] != A[msb]).
  - Result is bit-exact with the ideal DATA_WIDTH+1 addition.
- Latency: an operand accepted at edge N gives out_valid=1 after edge N+NUM_STAGES, provided no stall occurs.
- Handshake:
  - Transfer in: in_valid && in_ready at a rising edge.
  - Transfer out: out_valid && out_ready.
  - advance = !out_valid || out_ready, and in_ready = advance (combinational from out_ready).
  - When advance=0, every stage holds its contents, including bubbles.
  - When advance=1, all stages shift by one; a bubble enters if in_valid=0.
- Output stability: while out_valid && !out_ready, sum_ext, overflow and out_tag must not change.
- Throughput: sustained one result per cycle with out_ready held high.
- Simultaneous events: a result leaves and a new operand enters in the same cycle when out_ready=1, even with the pipe full.
- in_valid and operand values are don't-care while in_ready=0; the bench must not rely on them being ignored beyond that.
- NUM_STAGES=1: the block behaves as a registered ripple-carry adder with the same handshake.

Optional Feature:
- Macro: ADDER_PIPE_SAT_EN.
- Defined:
  - An operation accepted with sat_req=1 that sets overflow delivers the clamped signed result on sum_ext[DATA_WIDTH-1:0]: 0x7FFF_FFFF when A is non-negative, 0x8000_0000 when A is negative (values for DATA_WIDTH=32).
  - sum_ext[DATA_WIDTH] and overflow are unchanged from the raw computation.
  - The clamp is applied in the final stage; latency does not change.
- Not defined: sat_req is ignored (no logic, lint-waived) and the raw result is always delivered.

Test Plan:
All scenarios use DATA_WIDTH=32, NUM_STAGES=4, TAG_WIDTH=4.
1. Reset then single add, a=0xFFFF_FFFF, b=0x1, cin=0, tag=3 → out_valid at cycle 4 after accept; sum_ext=0x1_0000_0000, overflow=0, out_tag=3.
2. Subtract, a=0x0000_0005, b=0x0000_0007, op_sub=1 → sum_ext=0x0_FFFF_FFFE (borrow, carry=0), overflow=0. Then a=0x8000_0000, b=0x1, op_sub=1 → sum_ext=0x1_7FFF_FFFF, overflow=1.
3. Back-pressure: stream 10 ops with tags 0..9 and hold out_ready=0 for 6 cycles once out_valid rises → in_ready=0 during the stall, the first output held stable, and all 10 results emerge in order with no loss or duplication.
4. Full throughput: 100 random ops with in_valid=1 and out_ready=1 → 100 results on 100 consecutive cycles, each matching the reference model.
5. Reset mid-stream: 3 ops in flight, then assert rst for 1 cycle → no out_valid follows; the next op after reset returns correctly at latency 4.
6. ADDER_PIPE_SAT_EN defined: a=0x7FFF_FFFF, b=0x1, sat_req=1 → sum_ext[31:0]=0x7FFF_FFFF, overflow=1. With the macro undefined → sum_ext[31:0]=0x8000_0000.

Source files
------------

// File: rtl/adder_pipe_if.sv
// Operand/result handshake bundle for adder_pipe.
// master = operand source and result consumer, slave = the adder.
interface adder_pipe_if #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic                  cin;
    logic                  op_sub;
    logic                  sat_req;
    logic [TAG_WIDTH-1:0]  in_tag;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH:0]   sum_ext;
    logic                  overflow;
    logic [TAG_WIDTH-1:0]  out_tag;

    modport master (
        output in_valid, a, b, cin, op_sub, sat_req, in_tag, out_ready,
        input  in_ready, out_valid, sum_ext, overflow, out_tag
    );

    modport slave (
        input  in_valid, a, b, cin, op_sub, sat_req, in_tag, out_ready,
        output in_ready, out_valid, sum_ext, overflow, out_tag
    );
endinterface

// File: rtl/adder_pipe.sv
// Pipelined add/subtract unit: carry chain cut into NUM_STAGES segments, valid/ready with stall.
// Optional signed saturation on overflow is built when ADDER_PIPE_SAT_EN is defined.
module adder_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_STAGES = 4,
    parameter int TAG_WIDTH  = 4
) (
    input  logic        clk,
    input  logic        rst,
    adder_pipe_if.slave bus
);
    localparam int SEG  = DATA_WIDTH / NUM_STAGES;
    localparam int MSB  = DATA_WIDTH - 1;
    localparam int LAST = NUM_STAGES - 1;

    if (NUM_STAGES < 1 || NUM_STAGES > DATA_WIDTH) begin : g_bad_stages
        $error("adder_pipe: NUM_STAGES must lie in 1..DATA_WIDTH");
    end
    if ((DATA_WIDTH % NUM_STAGES) != 0) begin : g_bad_seg
        $error("adder_pipe: DATA_WIDTH must be divisible by NUM_STAGES");
    end

    // Rank 0 holds captured operands; rank k has k carry segments resolved.
    logic [NUM_STAGES-1:0] vld_q, vld_d;
    logic [NUM_STAGES-1:0] cy_q,  cy_d;
    logic [NUM_STAGES-1:0] sub_q, sub_d;
    logic [NUM_STAGES-1:0] sat_q, sat_d;
    logic [DATA_WIDTH-1:0] a_q   [NUM_STAGES];
    logic [DATA_WIDTH-1:0] a_d   [NUM_STAGES];
    logic [DATA_WIDTH-1:0] b_q   [NUM_STAGES];
    logic [DATA_WIDTH-1:0] b_d   [NUM_STAGES];
    logic [DATA_WIDTH-1:0] sum_q [NUM_STAGES];
    logic [DATA_WIDTH-1:0] sum_d [NUM_STAGES];
    logic [TAG_WIDTH-1:0]  tag_q [NUM_STAGES];
    logic [TAG_WIDTH-1:0]  tag_d [NUM_STAGES];

    logic                  out_vld_q, out_vld_d;
    logic [DATA_WIDTH:0]   sum_ext_q, sum_ext_d;
    logic                  ovf_q,     ovf_d;
    logic [TAG_WIDTH-1:0]  out_tag_q, out_tag_d;

    logic                  advance_s;
    logic [SEG:0]          seg_s;
    logic [SEG:0]          fin_seg_s;
    logic [DATA_WIDTH-1:0] res_s;
    logic [DATA_WIDTH-1:0] out_sum_s;
    logic                  raw_ovf_s;
    logic                  unused_s;

    assign unused_s = ^{sub_q, sat_q};

    // Whole pipe moves together; a held result freezes every rank, bubbles included.
    assign advance_s     = !out_vld_q || bus.out_ready;
    assign bus.in_ready  = advance_s;
    assign bus.out_valid = out_vld_q;
    assign bus.sum_ext   = sum_ext_q;
    assign bus.overflow  = ovf_q;
    assign bus.out_tag   = out_tag_q;

    // Next-state of every rank plus the final segment, overflow and clamp.
    always_comb begin
        vld_d = vld_q;
        cy_d  = cy_q;
        sub_d = sub_q;
        sat_d = sat_q;
        a_d   = a_q;
        b_d   = b_q;
        sum_d = sum_q;
        tag_d = tag_q;
        seg_s = '0;

        vld_d[0] = bus.in_valid;
        a_d[0]   = bus.a;
        b_d[0]   = bus.op_sub ? ~bus.b : bus.b;
        cy_d[0]  = bus.op_sub ? 1'b1 : bus.cin;
        sub_d[0] = bus.op_sub;
        sat_d[0] = bus.sat_req;
        tag_d[0] = bus.in_tag;
        sum_d[0] = '0;

        for (int k = 1; k < NUM_STAGES; k++) begin
            seg_s = {1'b0, a_q[k-1][(k-1)*SEG +: SEG]}
                  + {1'b0, b_q[k-1][(k-1)*SEG +: SEG]}
                  + {{SEG{1'b0}}, cy_q[k-1]};
            vld_d[k] = vld_q[k-1];
            a_d[k]   = a_q[k-1];
            b_d[k]   = b_q[k-1];
            sub_d[k] = sub_q[k-1];
            sat_d[k] = sat_q[k-1];
            tag_d[k] = tag_q[k-1];
            sum_d[k] = sum_q[k-1];
            sum_d[k][(k-1)*SEG +: SEG] = seg_s[SEG-1:0];
            cy_d[k]  = seg_s[SEG];
        end

        fin_seg_s = {1'b0, a_q[LAST][LAST*SEG +: SEG]}
                  + {1'b0, b_q[LAST][LAST*SEG +: SEG]}
                  + {{SEG{1'b0}}, cy_q[LAST]};
        res_s = sum_q[LAST];
        res_s[LAST*SEG +: SEG] = fin_seg_s[SEG-1:0];
        raw_ovf_s = (a_q[LAST][MSB] == b_q[LAST][MSB]) && (res_s[MSB] != a_q[LAST][MSB]);

        out_sum_s = res_s;
`ifdef ADDER_PIPE_SAT_EN
        if (sat_q[LAST] && raw_ovf_s) begin
            out_sum_s = a_q[LAST][MSB] ? {1'b1, {MSB{1'b0}}} : {1'b0, {MSB{1'b1}}};
        end else begin
            out_sum_s = res_s;
        end
`endif

        out_vld_d = vld_q[LAST];
        sum_ext_d = {fin_seg_s[SEG], out_sum_s};
        ovf_d     = raw_ovf_s;
        out_tag_d = tag_q[LAST];
    end

    // Pipeline and output registers; reset discards everything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q     <= '0;
            cy_q      <= '0;
            sub_q     <= '0;
            sat_q     <= '0;
            a_q       <= '{default: '0};
            b_q       <= '{default: '0};
            sum_q     <= '{default: '0};
            tag_q     <= '{default: '0};
            out_vld_q <= 1'b0;
            sum_ext_q <= '0;
            ovf_q     <= 1'b0;
            out_tag_q <= '0;
        end else if (advance_s) begin
            vld_q     <= vld_d;
            cy_q      <= cy_d;
            sub_q     <= sub_d;
            sat_q     <= sat_d;
            a_q       <= a_d;
            b_q       <= b_d;
            sum_q     <= sum_d;
            tag_q     <= tag_d;
            out_vld_q <= out_vld_d;
            sum_ext_q <= sum_ext_d;
            ovf_q     <= ovf_d;
            out_tag_q <= out_tag_d;
        end
    end
endmodule

// File: tb/tb_adder_pipe.sv
// Scoreboard bench for adder_pipe: accepted operands push an arithmetic model result,
// a monitor pops and compares on every output transfer.
module tb_adder_pipe;
    localparam int DW  = 32;
    localparam int NS  = 4;
    localparam int TW  = 4;
    localparam int LAT = 4;

    typedef struct {
        logic [DW:0]   sum;
        logic          ovf;
        logic [TW-1:0] tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    exp_t exp_q[$];
    int   n_cmp   = 0;
    int   n_err   = 0;
    int   out_cnt = 0;
    int   base;

    always #5 clk = ~clk;

    adder_pipe_if #(.DATA_WIDTH(DW), .TAG_WIDTH(TW)) bus ();

    adder_pipe #(.DATA_WIDTH(DW), .NUM_STAGES(NS), .TAG_WIDTH(TW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic exp_t model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                   input logic cin, input logic sub, input logic sat,
                                   input logic [TW-1:0] tag);
        exp_t   e;
        longint sa;
        longint sb;
        longint r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (sub) begin
            r     = sa - sb;
            e.sum = {(a >= b), a - b};
        end else begin
            r     = sa + sb + longint'(cin);
            e.sum = {1'b0, a} + {1'b0, b} + {{DW{1'b0}}, cin};
        end
        e.ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
`ifdef ADDER_PIPE_SAT_EN
        if (sat && e.ovf) e.sum[DW-1:0] = (sa < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
`else
        if (sat && e.ovf) e.sum[DW] = e.sum[DW];
`endif
        e.tag = tag;
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Scoreboard push: an operand is accepted at the edge following this sample.
    always @(negedge clk) begin
        if (!rst && bus.in_valid && bus.in_ready)
            exp_q.push_back(model(bus.a, bus.b, bus.cin, bus.op_sub, bus.sat_req, bus.in_tag));
    end

    // Monitor: compare every output transfer against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.out_valid && bus.out_ready) begin
            out_cnt++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_output: actual tag=%0h sum=%0h required no output",
                         bus.out_tag, bus.sum_ext);
            end else begin
                e = exp_q.pop_front();
                check("sb_sum", 64'(bus.sum_ext), 64'(e.sum));
                check("sb_ovf", 64'(bus.overflow), 64'(e.ovf));
                check("sb_tag", 64'(bus.out_tag), 64'(e.tag));
            end
        end
    end

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic cin,
                        input logic sub, input logic sat, input logic [TW-1:0] tag);
        logic done;
        done        = 1'b0;
        bus.in_valid = 1'b1;
        bus.a       = a;
        bus.b       = b;
        bus.cin     = cin;
        bus.op_sub  = sub;
        bus.sat_req = sat;
        bus.in_tag  = tag;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                @(posedge clk);
                #1;
                done = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!done) check("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic send_rand(input logic [TW-1:0] tag);
        send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), tag);
    endtask

    task automatic send_check(input string name, input logic [DW-1:0] a, input logic [DW-1:0] b,
                              input logic cin, input logic sub, input logic sat,
                              input logic [TW-1:0] tag, input logic [DW:0] es, input logic eo);
        int lat;
        send(a, b, cin, sub, sat, tag);
        idle();
        lat = 0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.out_valid) begin
                lat = n;
                break;
            end
        end
        check({name, "_latency"}, 64'(lat), 64'(LAT));
        check({name, "_sum"}, 64'(bus.sum_ext), 64'(es));
        check({name, "_ovf"}, 64'(bus.overflow), 64'(eo));
        check({name, "_tag"}, 64'(bus.out_tag), 64'(tag));
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int target);
        for (int i = 0; i < 200; i++) begin
            if (out_cnt >= target) break;
            @(negedge clk);
        end
        check("drain_count", 64'(out_cnt), 64'(target));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.op_sub    = 1'b0;
        bus.sat_req   = 1'b0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_sum_ext", 64'(bus.sum_ext), 64'd0);
        check("rst_overflow", 64'(bus.overflow), 64'd0);
        check("rst_out_tag", 64'(bus.out_tag), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Directed arithmetic corners.
        send_check("add_carry", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 4'd3,
                   33'h1_0000_0000, 1'b0);
        send_check("sub_borrow", 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 1'b0, 4'd5,
                   33'h0_FFFF_FFFE, 1'b0);
        send_check("sub_ovf", 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 1'b0, 4'd6,
                   33'h1_7FFF_FFFF, 1'b1);
`ifdef ADDER_PIPE_SAT_EN
        send_check("sat", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 4'd7,
                   33'h0_7FFF_FFFF, 1'b1);
`else
        send_check("sat", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 4'd7,
                   33'h0_8000_0000, 1'b1);
`endif

        // Back-pressure: stall the first result while ten operations stream in.
        base          = out_cnt;
        bus.out_ready = 1'b0;
        fork
            begin
                for (int t = 0; t < 10; t++) send_rand(TW'(t));
                idle();
            end
            begin
                logic [DW:0] snap;
                int          seen;
                seen = 0;
                for (int i = 0; i < 40; i++) begin
                    @(negedge clk);
                    if (bus.out_valid) begin
                        seen = 1;
                        break;
                    end
                end
                check("bp_valid_seen", 64'(seen), 64'd1);
                snap = bus.sum_ext;
                for (int i = 0; i < 6; i++) begin
                    check("bp_in_ready", 64'(bus.in_ready), 64'd0);
                    check("bp_out_valid", 64'(bus.out_valid), 64'd1);
                    check("bp_hold_tag", 64'(bus.out_tag), 64'd0);
                    check("bp_hold_sum", 64'(bus.sum_ext), 64'(snap));
                    @(posedge clk);
                    #1;
                    @(negedge clk);
                end
                @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        drain(base + 10);

        // Full throughput: one result per cycle for 100 random operations.
        base = out_cnt;
        fork
            begin
                for (int t = 0; t < 100; t++) send_rand(TW'(t));
                idle();
            end
            begin
                int v;
                v = 0;
                for (int i = 0; i < 50; i++) begin
                    @(negedge clk);
                    if (bus.out_valid) break;
                end
                for (int i = 0; i < 100; i++) begin
                    if (bus.out_valid) v++;
                    if (i < 99) @(negedge clk);
                end
                check("throughput_valid_cycles", 64'(v), 64'd100);
            end
        join
        drain(base + 100);

        // Reset with three operations in flight: none may emerge.
        for (int t = 0; t < 3; t++) send_rand(TW'(t + 10));
        rst = 1'b1;
        idle();
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        begin
            int seen;
            seen = 0;
            repeat (10) begin
                @(negedge clk);
                if (bus.out_valid) seen++;
            end
            check("flush_no_output", 64'(seen), 64'd0);
        end
        @(posedge clk);
        #1;
        send_check("post_reset", 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 1'b0, 4'd9,
                   33'h0_2345_678A, 1'b0);

        repeat (5) @(posedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
